// File: rtl/winograd_input_tile_fetcher.sv
// rtl/winograd_input_tile_fetcher.sv - gathers 6x6 Winograd input tiles from feature-map SRAM
//
// Purpose: walks one feature-map channel in raster tile order and assembles each 6x6 input
// tile (stride 4 / pad 1 for 3x3 weights, stride 6 / pad 0 for 1x1 weights). Each tile is
// presented with the output-pixel index range it covers on a valid/ready interface.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   start                        begin a scan (sampled in IDLE only)
//   fm_height, fm_width          feature-map size, latched at start
//   fm_base_addr                 word address of pixel (0,0), row-major, latched at start
//   weight_size                  0 = 1x1, 1 = 3x3, latched at start
//   mem_rd_en, mem_rd_addr       SRAM read request
//   mem_rd_data                  SRAM read data, one cycle after mem_rd_en
//   input_tile[0:35]             tile element r*6+c, signed
//   input_valid, input_ready     tile handshake
//   input_{low,high}_*_index     output rows/cols covered by the tile
//   busy                         not IDLE
//   done                         one-cycle pulse after the last tile is accepted
module winograd_input_tile_fetcher #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 9,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [IDX_W-1:0]         fm_height,
    input  logic [IDX_W-1:0]         fm_width,
    input  logic [ADDR_W-1:0]        fm_base_addr,
    input  logic                     weight_size,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic signed [DATA_W-1:0] input_tile [0:35],
    output logic                     input_valid,
    input  logic                     input_ready,
    output logic [IDX_W-1:0]         input_low_weight_index,
    output logic [IDX_W-1:0]         input_high_weight_index,
    output logic [IDX_W-1:0]         input_low_height_index,
    output logic [IDX_W-1:0]         input_high_height_index,
    output logic                     busy,
    output logic                     done
);
    // Pixel coordinates are signed and one bit wider than needed so the -1 pad origin fits.
    localparam int CW = IDX_W + 2;

    localparam logic [ADDR_W-1:0]      A_ZERO = '0;
    localparam logic [ADDR_W-1:0]      A_ONE  = 1;
    localparam logic [ADDR_W-1:0]      A_FIVE = 5;
    localparam logic signed [CW-1:0]   C_ONE  = 1;
    localparam logic signed [CW-1:0]   C_FIVE = 5;
    localparam logic [IDX_W:0]         I_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t r_state, w_state_nx;

    // Latched configuration
    logic [IDX_W-1:0]       r_h, r_w;
    logic                   r_ws;

    // Current tile position: first covered output row/col and SRAM address of the tile origin
    logic [IDX_W-1:0]       r_low_h, r_low_w;
    logic [ADDR_W-1:0]      r_row_addr;   // origin address of tile (tr, 0)
    logic [ADDR_W-1:0]      r_tile_addr;  // origin address of tile (tr, tc)

    // Element walk inside the tile
    logic [5:0]             r_k;
    logic [2:0]             r_c;
    logic signed [CW-1:0]   r_y, r_x;
    logic [ADDR_W-1:0]      r_addr;

    // Read in flight: which element it fills and whether it was a real read or padding
    logic                   r_pend;
    logic [5:0]             r_pend_k;
    logic                   r_pend_inb;

    logic [IDX_W:0]         w_s;
    logic [ADDR_W-1:0]      w_sa, w_w_a, w_sw;
    logic                   w_inb;
    logic                   w_start_ok;
    logic [ADDR_W-1:0]      w_init_addr;
    logic [CW-1:0]          w_init_org;
    logic [IDX_W:0]         w_lw_sum, w_lh_sum;
    logic                   w_wrap, w_last;
    logic [IDX_W-1:0]       w_nx_low_h, w_nx_low_w;
    logic [ADDR_W-1:0]      w_nx_row_addr, w_nx_tile_addr;
    logic [CW-1:0]          w_nx_oy, w_nx_ox;

    function automatic logic [IDX_W-1:0] f_high(input logic [IDX_W-1:0] low,
                                                input logic [IDX_W-1:0] n,
                                                input logic [IDX_W:0]   s);
        logic [IDX_W:0] cand, lim;
        cand = {1'b0, low} + s - I_ONE;
        lim  = {1'b0, n} - I_ONE;
        return (cand < lim) ? cand[IDX_W-1:0] : lim[IDX_W-1:0];
    endfunction

    assign w_s   = r_ws ? (IDX_W+1)'(4) : (IDX_W+1)'(6);
    assign w_sa  = ADDR_W'(w_s);
    assign w_w_a = ADDR_W'(r_w);
    // One tile row down in SRAM: S*W built from shifts
    assign w_sw  = r_ws ? (w_w_a << 2) : ((w_w_a << 2) + (w_w_a << 1));

    assign w_inb = !r_y[CW-1] && (r_y < $signed({2'b00, r_h})) &&
                   !r_x[CW-1] && (r_x < $signed({2'b00, r_w}));

    assign w_start_ok  = (fm_height != '0) && (fm_width != '0);
    // First tile origin is (-P,-P): base - P*W - P
    assign w_init_addr = fm_base_addr - (weight_size ? (ADDR_W'(fm_width) + A_ONE) : A_ZERO);
    assign w_init_org  = {CW{weight_size}};

    // Next tile in raster order
    assign w_lw_sum       = {1'b0, r_low_w} + w_s;
    assign w_lh_sum       = {1'b0, r_low_h} + w_s;
    assign w_wrap         = (w_lw_sum >= {1'b0, r_w});
    assign w_last         = w_wrap && (w_lh_sum >= {1'b0, r_h});
    assign w_nx_low_h     = w_wrap ? w_lh_sum[IDX_W-1:0] : r_low_h;
    assign w_nx_low_w     = w_wrap ? '0 : w_lw_sum[IDX_W-1:0];
    assign w_nx_row_addr  = w_wrap ? (r_row_addr + w_sw) : r_row_addr;
    assign w_nx_tile_addr = w_wrap ? (r_row_addr + w_sw) : (r_tile_addr + w_sa);
    assign w_nx_oy        = {2'b00, w_nx_low_h} - {{(CW-1){1'b0}}, r_ws};
    assign w_nx_ox        = {2'b00, w_nx_low_w} - {{(CW-1){1'b0}}, r_ws};

    assign mem_rd_en   = (r_state == S_FETCH) && w_inb;
    assign mem_rd_addr = mem_rd_en ? r_addr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        input_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nx = w_start_ok ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (r_k == 6'd35) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                w_state_nx = S_EMIT;
            end
            S_EMIT: begin
                input_valid = 1'b1;
                if (input_ready) begin
                    w_state_nx = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h                     <= '0;
            r_w                     <= '0;
            r_ws                    <= 1'b0;
            r_low_h                 <= '0;
            r_low_w                 <= '0;
            r_row_addr              <= '0;
            r_tile_addr             <= '0;
            r_k                     <= '0;
            r_c                     <= '0;
            r_y                     <= '0;
            r_x                     <= '0;
            r_addr                  <= '0;
            r_pend                  <= 1'b0;
            r_pend_k                <= '0;
            r_pend_inb              <= 1'b0;
            input_low_height_index  <= '0;
            input_high_height_index <= '0;
            input_low_weight_index  <= '0;
            input_high_weight_index <= '0;
            for (int i = 0; i < 36; i++) begin
                input_tile[i] <= '0;
            end
        end else begin
            // Element k lands one cycle after its FETCH slot; padding slots write zero.
            if (r_pend) begin
                input_tile[r_pend_k] <= r_pend_inb ? $signed(mem_rd_data) : '0;
            end
            r_pend     <= (r_state == S_FETCH);
            r_pend_k   <= r_k;
            r_pend_inb <= mem_rd_en;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_h  <= fm_height;
                        r_w  <= fm_width;
                        r_ws <= weight_size;
                        if (w_start_ok) begin
                            r_low_h     <= '0;
                            r_low_w     <= '0;
                            r_row_addr  <= w_init_addr;
                            r_tile_addr <= w_init_addr;
                            r_addr      <= w_init_addr;
                            r_y         <= $signed(w_init_org);
                            r_x         <= $signed(w_init_org);
                            r_k         <= '0;
                            r_c         <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    r_k <= r_k + 6'd1;
                    if (r_c == 3'd5) begin
                        // Wrap to column 0 of the next tile row
                        r_c    <= '0;
                        r_y    <= r_y + C_ONE;
                        r_x    <= r_x - C_FIVE;
                        r_addr <= r_addr + w_w_a - A_FIVE;
                    end else begin
                        r_c    <= r_c + 3'd1;
                        r_x    <= r_x + C_ONE;
                        r_addr <= r_addr + A_ONE;
                    end
                end
                S_WAIT: begin
                    input_low_height_index  <= r_low_h;
                    input_high_height_index <= f_high(r_low_h, r_h, w_s);
                    input_low_weight_index  <= r_low_w;
                    input_high_weight_index <= f_high(r_low_w, r_w, w_s);
                end
                S_EMIT: begin
                    if (input_ready && !w_last) begin
                        r_low_h     <= w_nx_low_h;
                        r_low_w     <= w_nx_low_w;
                        r_row_addr  <= w_nx_row_addr;
                        r_tile_addr <= w_nx_tile_addr;
                        r_addr      <= w_nx_tile_addr;
                        r_y         <= $signed(w_nx_oy);
                        r_x         <= $signed(w_nx_ox);
                        r_k         <= '0;
                        r_c         <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_input_tile_fetcher.sv
// tb/tb_winograd_input_tile_fetcher.sv - directed self-checking bench for the Winograd tile fetcher
module tb_winograd_input_tile_fetcher;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 9;
    localparam int ADDR_W = 16;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [IDX_W-1:0]         fm_height;
    logic [IDX_W-1:0]         fm_width;
    logic [ADDR_W-1:0]        fm_base_addr;
    logic                     weight_size;
    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_rd_addr;
    logic [DATA_W-1:0]        mem_rd_data;
    logic signed [DATA_W-1:0] input_tile [0:35];
    logic                     input_valid;
    logic                     input_ready;
    logic [IDX_W-1:0]         input_low_weight_index;
    logic [IDX_W-1:0]         input_high_weight_index;
    logic [IDX_W-1:0]         input_low_height_index;
    logic [IDX_W-1:0]         input_high_height_index;
    logic                     busy;
    logic                     done;

    winograd_input_tile_fetcher #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .fm_height               (fm_height),
        .fm_width                (fm_width),
        .fm_base_addr            (fm_base_addr),
        .weight_size             (weight_size),
        .mem_rd_en               (mem_rd_en),
        .mem_rd_addr             (mem_rd_addr),
        .mem_rd_data             (mem_rd_data),
        .input_tile              (input_tile),
        .input_valid             (input_valid),
        .input_ready             (input_ready),
        .input_low_weight_index  (input_low_weight_index),
        .input_high_weight_index (input_high_weight_index),
        .input_low_height_index  (input_low_height_index),
        .input_high_height_index (input_high_height_index),
        .busy                    (busy),
        .done                    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    initial mem_rd_data = '0;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int n_checks = 0;
    int n_errors = 0;
    int rd_count = 0;
    int oob_count = 0;
    int cur_base = 0;
    int cur_n = 0;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_count++;
            if (((int'(mem_rd_addr) - cur_base) & 32'hFFFF) >= cur_n) oob_count++;
        end
    end

    typedef struct {
        int h; int w; int ws; int base; int disturb;
        int exp_tiles; int exp_reads; int exp_first_valid; int exp_done;
    } vec_t;

    vec_t vecs [0:6];
    logic [7:0] snap_tile [0:35];
    int last_lh, last_hh, last_lw, last_hw;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_elem(input int h, input int w, input int ws,
                                            input int tr, input int tc, input int k);
        int s, p, y, x;
        s = (ws != 0) ? 4 : 6;
        p = (ws != 0) ? 1 : 0;
        y = tr * s - p + k / 6;
        x = tc * s - p + k % 6;
        if (y < 0 || y >= h || x < 0 || x >= w) return 8'h00;
        return 8'((y * w + x + 1) & 255);
    endfunction

    task automatic fill_mem(input int base, input int n);
        for (int i = 0; i < 65536; i++) mem[i] = 8'hA5;
        for (int i = 0; i < n; i++) mem[(base + i) & 16'hFFFF] = 8'((i + 1) & 255);
        cur_base = base;
        cur_n    = n;
    endtask

    task automatic check_all_zero(input string tag);
        bit tz = 1'b1;
        bit cz = 1'b1;
        for (int k = 0; k < 36; k++) if (input_tile[k] !== 8'sd0) tz = 1'b0;
        if (input_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 ||
            mem_rd_addr !== '0 || input_low_weight_index !== '0 ||
            input_high_weight_index !== '0 || input_low_height_index !== '0 ||
            input_high_height_index !== '0) cz = 1'b0;
        chk(tz, {tag, "_tile_zero"}, int'(tz), 1);
        chk(cz, {tag, "_ctrl_zero"}, int'(busy), 0);
    endtask

    task automatic run_scan(input vec_t v, input string tag);
        int s, th, tw, idx, ntiles, first_valid, done_idx, bad, tr, tc, elh, ehh, elw, ehw;
        s  = (v.ws != 0) ? 4 : 6;
        th = (v.h + s - 1) / s;
        tw = (v.w + s - 1) / s;
        fill_mem(v.base, v.h * v.w);
        @(negedge clk);
        rd_count     = 0;
        oob_count    = 0;
        fm_height    = IDX_W'(v.h);
        fm_width     = IDX_W'(v.w);
        fm_base_addr = ADDR_W'(v.base);
        weight_size  = (v.ws != 0);
        input_ready  = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        idx         = 0;
        ntiles      = 0;
        first_valid = -1;
        done_idx    = -1;
        while (idx < 3000 && done_idx < 0) begin
            if (v.disturb != 0 && (idx == 10 || idx == 50)) begin
                start        = 1'b1;
                fm_height    = 9'd3;
                fm_width     = 9'd2;
                weight_size  = 1'b0;
                fm_base_addr = 16'h0000;
            end else begin
                start = 1'b0;
            end
            if (idx == 5) chk(busy === 1'b1, {tag, " busy_mid_scan"}, int'(busy), 1);
            if (input_valid) begin
                if (first_valid < 0) first_valid = idx;
                if (ntiles < th * tw) begin
                    tr  = ntiles / tw;
                    tc  = ntiles % tw;
                    bad = -1;
                    for (int k = 0; k < 36; k++)
                        if (bad < 0 && input_tile[k] !== exp_elem(v.h, v.w, v.ws, tr, tc, k)) bad = k;
                    chk(bad < 0, $sformatf("%s tile%0d_data_k%0d", tag, ntiles, bad),
                        (bad < 0) ? 0 : int'(input_tile[bad]),
                        (bad < 0) ? 0 : int'(exp_elem(v.h, v.w, v.ws, tr, tc, bad)));
                    elh = tr * s;
                    ehh = (elh + s - 1 < v.h - 1) ? elh + s - 1 : v.h - 1;
                    elw = tc * s;
                    ehw = (elw + s - 1 < v.w - 1) ? elw + s - 1 : v.w - 1;
                    chk(int'(input_low_height_index) == elh && int'(input_high_height_index) == ehh &&
                        int'(input_low_weight_index) == elw && int'(input_high_weight_index) == ehw,
                        $sformatf("%s tile%0d_idx h=%0d..%0d w=%0d..%0d", tag, ntiles,
                                  input_low_height_index, input_high_height_index,
                                  input_low_weight_index, input_high_weight_index),
                        int'(input_high_weight_index), ehw);
                    if (ntiles == 0) for (int k = 0; k < 36; k++) snap_tile[k] = input_tile[k];
                    last_lh = int'(input_low_height_index);
                    last_hh = int'(input_high_height_index);
                    last_lw = int'(input_low_weight_index);
                    last_hw = int'(input_high_weight_index);
                end
                ntiles++;
            end
            if (done) begin
                done_idx = idx;
            end else begin
                @(negedge clk);
                idx++;
            end
        end
        start = 1'b0;
        chk(done_idx >= 0, {tag, " scan_timeout"}, idx, v.exp_done);
        chk(ntiles == v.exp_tiles, {tag, " tile_count"}, ntiles, v.exp_tiles);
        chk(rd_count == v.exp_reads, {tag, " read_count"}, rd_count, v.exp_reads);
        chk(oob_count == 0, {tag, " oob_reads"}, oob_count, 0);
        chk(first_valid == v.exp_first_valid, {tag, " first_valid_cycle"}, first_valid,
            v.exp_first_valid);
        chk(done_idx == v.exp_done, {tag, " done_cycle"}, done_idx, v.exp_done);
        @(negedge clk);
        chk(done === 1'b0 && busy === 1'b0, {tag, " done_one_cycle"}, int'(done), 0);
    endtask

    logic [7:0] hold_tile [0:35];
    int hold_idx [0:3];

    initial begin
        // {h, w, ws, base, disturb, tiles, reads, first valid cycle, done cycle}
        vecs[0] = '{4,  4,  1, 'h0100, 0, 1, 16,  37, 38};
        vecs[1] = '{12, 12, 0, 'h2000, 0, 4, 144, 37, 152};
        vecs[2] = '{5,  5,  1, 'h0300, 0, 4, 49,  37, 152};
        vecs[3] = '{7,  9,  1, 'hFFF0, 0, 6, 117, 37, 228};
        vecs[4] = '{1,  1,  0, 'h0040, 0, 1, 1,   37, 38};
        vecs[5] = '{13, 6,  0, 'h0050, 0, 3, 78,  37, 114};
        vecs[6] = '{5,  5,  1, 'h0300, 1, 4, 49,  37, 152};

        reset        = 1'b1;
        start        = 1'b0;
        fm_height    = '0;
        fm_width     = '0;
        fm_base_addr = '0;
        weight_size  = 1'b0;
        input_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_scan(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                bit z = 1'b1;
                for (int k = 0; k < 7; k++) if (snap_tile[k] !== 8'h00) z = 1'b0;
                for (int k = 30; k < 36; k++) if (snap_tile[k] !== 8'h00) z = 1'b0;
                chk(z, "t1_pad_zero", int'(z), 1);
                chk(snap_tile[7] == 8'd1, "t1_tile7", int'(snap_tile[7]), 1);
                chk(snap_tile[10] == 8'd4, "t1_tile10", int'(snap_tile[10]), 4);
                chk(snap_tile[28] == 8'd16, "t1_tile28", int'(snap_tile[28]), 16);
                chk(last_lh == 0 && last_hh == 3 && last_lw == 0 && last_hw == 3,
                    "t1_indices", last_hh, 3);
            end
            if (i == 2) begin
                chk(last_lh == 4 && last_hh == 4 && last_lw == 4 && last_hw == 4,
                    "t4_last_indices", last_hh, 4);
            end
        end

        // Stall in EMIT, resume, then reset in the middle of the next FETCH
        fill_mem('h2000, 144);
        @(negedge clk);
        fm_height    = 9'd12;
        fm_width     = 9'd12;
        fm_base_addr = 16'h2000;
        weight_size  = 1'b0;
        input_ready  = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            bit stable, rd_seen;
            n = 0;
            while (!input_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk(input_valid === 1'b1, "stall_valid_reached", n, 37);
            for (int k = 0; k < 36; k++) hold_tile[k] = input_tile[k];
            hold_idx[0] = int'(input_low_height_index);
            hold_idx[1] = int'(input_high_height_index);
            hold_idx[2] = int'(input_low_weight_index);
            hold_idx[3] = int'(input_high_weight_index);
            stable  = 1'b1;
            rd_seen = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (input_valid !== 1'b1) stable = 1'b0;
                for (int k = 0; k < 36; k++) if (input_tile[k] !== hold_tile[k]) stable = 1'b0;
                if (int'(input_low_height_index) != hold_idx[0] ||
                    int'(input_high_height_index) != hold_idx[1] ||
                    int'(input_low_weight_index) != hold_idx[2] ||
                    int'(input_high_weight_index) != hold_idx[3]) stable = 1'b0;
                if (mem_rd_en) rd_seen = 1'b1;
            end
            chk(stable, "stall_outputs_stable", int'(stable), 1);
            chk(!rd_seen, "stall_no_reads", int'(rd_seen), 0);
            chk(hold_idx[1] == 5 && hold_idx[3] == 5, "stall_tile0_idx", hold_idx[3], 5);
            input_ready = 1'b1;
            @(negedge clk);
            chk(input_valid === 1'b0 && mem_rd_en === 1'b1 && mem_rd_addr == 16'h2006,
                "stall_resume_fetch", int'(mem_rd_addr), 'h2006);
            repeat (20) @(negedge clk);
            chk(mem_rd_en === 1'b1 && mem_rd_addr == 16'h202C, "fetch_k20_addr",
                int'(mem_rd_addr), 'h202C);
            reset = 1'b1;
            #1;
            check_all_zero("mid_scan_reset");
            @(negedge clk);
            reset = 1'b0;
        end
        run_scan(vecs[0], "post_reset");

        // Empty map: straight to DONE with no reads
        @(negedge clk);
        rd_count     = 0;
        fm_height    = 9'd0;
        fm_width     = 9'd5;
        weight_size  = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk(done === 1'b1 && busy === 1'b1, "h0_done_pulse", int'(done), 1);
        @(negedge clk);
        chk(done === 1'b0 && busy === 1'b0, "h0_back_idle", int'(done), 0);
        chk(rd_count == 0, "h0_no_reads", rd_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
